// File: rtl/kernel_convolution_stream.sv
// Streaming KxKxC window convolution against a reloadable kernel.
// Pipeline: tap products -> row sums -> total, shift and clip.
//
// state    | meaning
// UNLOADED | no valid kernel since reset, windows refused
// RUN      | accepting windows with the active kernel
// DRAIN    | reload pending, waiting for the pipeline to empty
// LOAD     | latching kernel_in, kernel_ack asserted
module kernel_convolution_stream #(
    parameter int KERNEL_SIZE = 3,
    parameter int CHANNELS    = 3,
    parameter int DATA_W      = 32,
    parameter int OUT_W       = 32,
    parameter int SHIFT       = 0
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               kernel_load,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_W-1:0] kernel_in,
    output logic                                               kernel_ack,
    input  logic                                               in_valid,
    output logic                                               in_ready,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_W-1:0] window_in,
    output logic                                               out_valid,
    input  logic                                               out_ready,
    output logic signed [OUT_W-1:0]                            ans,
    output logic                                               sat_flag
);
    localparam int NPROD  = KERNEL_SIZE*KERNEL_SIZE*CHANNELS;
    localparam int ROW_N  = KERNEL_SIZE*CHANNELS;
    localparam int VEC_W  = NPROD*DATA_W;
    localparam int PROD_W = 2*DATA_W;
    localparam int ACC_W  = PROD_W + $clog2(NPROD);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {UNLOADED, RUN, DRAIN, LOAD} state_t;

    state_t                   state, state_next;
    logic [VEC_W-1:0]         kernel_q;
    logic signed [PROD_W-1:0] prod_d [NPROD];
    logic signed [PROD_W-1:0] prod_q [NPROD];
    logic signed [ACC_W-1:0]  row_d [KERNEL_SIZE];
    logic signed [ACC_W-1:0]  row_q [KERNEL_SIZE];
    logic signed [ACC_W-1:0]  total, shifted;
    logic                     s1_valid, s2_valid, stall, accept, pipe_busy;

    // Element 0 (row 0, col 0, channel 0) sits at the MSBs of the vector.
    function automatic logic signed [DATA_W-1:0] elem(input logic [VEC_W-1:0] vec, input int e);
        return vec[(NPROD-1-e)*DATA_W +: DATA_W];
    endfunction

    assign stall     = out_valid && !out_ready;
    assign accept    = in_valid && in_ready;
    assign pipe_busy = s1_valid || s2_valid || out_valid;

    always_ff @(posedge clk) begin
        if (reset) state <= UNLOADED;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            UNLOADED: if (kernel_load) state_next = LOAD;
            RUN:      if (kernel_load) state_next = pipe_busy ? DRAIN : LOAD;
            DRAIN:    if (!pipe_busy)  state_next = LOAD;
            LOAD:     state_next = RUN;
            default:  state_next = UNLOADED;
        endcase
    end

    // A pending reload takes priority over a window offered in the same cycle.
    always_comb begin
        in_ready   = (state == RUN) && !kernel_load && !stall;
        kernel_ack = (state == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset)           kernel_q <= '0;
        else if (kernel_ack) kernel_q <= kernel_in;
    end

    always_comb begin
        for (int e = 0; e < NPROD; e++)
            prod_d[e] = PROD_W'(elem(window_in, e)) * PROD_W'(elem(kernel_q, e));
    end

    always_comb begin
        total = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            row_d[r] = '0;
            for (int k = 0; k < ROW_N; k++)
                row_d[r] = row_d[r] + ACC_W'(prod_q[r*ROW_N + k]);
            total = total + row_q[r];
        end
        shifted = total >>> SHIFT;
    end

    // The whole pipeline freezes while the output is back-pressured.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            ans       <= '0;
            sat_flag  <= 1'b0;
            for (int e = 0; e < NPROD; e++)       prod_q[e] <= '0;
            for (int r = 0; r < KERNEL_SIZE; r++) row_q[r]  <= '0;
        end else if (!stall) begin
            s1_valid  <= accept;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (accept)   prod_q <= prod_d;
            if (s1_valid) row_q  <= row_d;
            if (s2_valid) begin
                if (shifted > ACC_MAX) begin
                    ans      <= ACC_MAX[OUT_W-1:0];
                    sat_flag <= 1'b1;
                end else if (shifted < ACC_MIN) begin
                    ans      <= ACC_MIN[OUT_W-1:0];
                    sat_flag <= 1'b1;
                end else begin
                    ans      <= shifted[OUT_W-1:0];
                    sat_flag <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_kernel_convolution_stream.sv
// Bench for kernel_convolution_stream: three instances share stimulus
// (default, OUT_W=16, SHIFT=2); a scoreboard checks every result in order.
module tb_kernel_convolution_stream;
    localparam int K = 3, C = 3, DW = 32, NPROD = K*K*C, VEC_W = NPROD*DW;

    typedef logic [VEC_W-1:0] vec_t;
    typedef struct {
        vec_t   win;
        longint exp;
    } vec_rec_t;

    logic clk = 1'b0, reset = 1'b1, kernel_load = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    vec_t kernel_in = '0, window_in = '0;
    logic ack_a, ack_b, ack_c, rdy_a, rdy_b, rdy_c, ov_a, ov_b, ov_c, sat_a, sat_b, sat_c;
    logic signed [31:0] ans_a, ans_c;
    logic signed [15:0] ans_b;

    int     n_checks = 0, n_pass = 0, n_results = 0, stall_seen = 0;
    longint exp_q[$];
    longint drv_exp = 0;

    always #5 clk = ~clk;

    kernel_convolution_stream #(.KERNEL_SIZE(K), .CHANNELS(C), .DATA_W(DW), .OUT_W(32), .SHIFT(0)) dut_a (
        .clk(clk), .reset(reset), .kernel_load(kernel_load), .kernel_in(kernel_in), .kernel_ack(ack_a),
        .in_valid(in_valid), .in_ready(rdy_a), .window_in(window_in), .out_valid(ov_a),
        .out_ready(out_ready), .ans(ans_a), .sat_flag(sat_a));
    kernel_convolution_stream #(.KERNEL_SIZE(K), .CHANNELS(C), .DATA_W(DW), .OUT_W(16), .SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .kernel_load(kernel_load), .kernel_in(kernel_in), .kernel_ack(ack_b),
        .in_valid(in_valid), .in_ready(rdy_b), .window_in(window_in), .out_valid(ov_b),
        .out_ready(out_ready), .ans(ans_b), .sat_flag(sat_b));
    kernel_convolution_stream #(.KERNEL_SIZE(K), .CHANNELS(C), .DATA_W(DW), .OUT_W(32), .SHIFT(2)) dut_c (
        .clk(clk), .reset(reset), .kernel_load(kernel_load), .kernel_in(kernel_in), .kernel_ack(ack_c),
        .in_valid(in_valid), .in_ready(rdy_c), .window_in(window_in), .out_valid(ov_c),
        .out_ready(out_ready), .ans(ans_c), .sat_flag(sat_c));

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    function automatic vec_t put(input vec_t v, input int e, input longint val);
        logic [DW-1:0] x;
        x = DW'(val);
        v[(NPROD-1-e)*DW +: DW] = x;
        return v;
    endfunction

    function automatic vec_t uniform(input longint c0, input longint c1, input longint c2);
        vec_t v = '0;
        for (int t = 0; t < K*K; t++) begin
            v = put(v, t*C + 0, c0);
            v = put(v, t*C + 1, c1);
            v = put(v, t*C + 2, c2);
        end
        return v;
    endfunction

    // tap(i,j) = sgn * {i*j, i+j, j}
    function automatic vec_t test_win(input int sgn);
        vec_t v = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
                v = put(v, (i*K + j)*C + 0, longint'(sgn*i*j));
                v = put(v, (i*K + j)*C + 1, longint'(sgn*(i+j)));
                v = put(v, (i*K + j)*C + 2, longint'(sgn*j));
            end
        return v;
    endfunction

    function automatic longint model_sum(input vec_t w, input vec_t k);
        longint s;
        logic signed [DW-1:0] a, b;
        s = 0;
        for (int e = 0; e < NPROD; e++) begin
            a = w[(NPROD-1-e)*DW +: DW];
            b = k[(NPROD-1-e)*DW +: DW];
            s = s + longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic longint clip(input longint sum, input int sh, input int ow, output bit sat);
        longint s, mx, mn;
        s  = sum >>> sh;
        mx = (longint'(1) <<< (ow-1)) - 1;
        mn = -(longint'(1) <<< (ow-1));
        sat = 1'b1;
        if (s > mx) return mx;
        if (s < mn) return mn;
        sat = 1'b0;
        return s;
    endfunction

    task automatic check_result(input longint e);
        longint x;
        bit     s;
        chk(ov_b && ov_c, "out_valid_bc", longint'({ov_b, ov_c}), 3);
        x = clip(e, 0, 32, s);
        chk(longint'(ans_a) == x, "ans_a", longint'(ans_a), x);
        chk(sat_a == s, "sat_a", longint'(sat_a), longint'(s));
        x = clip(e, 0, 16, s);
        chk(longint'(ans_b) == x, "ans_b_out16", longint'(ans_b), x);
        chk(sat_b == s, "sat_b_out16", longint'(sat_b), longint'(s));
        x = clip(e, 2, 32, s);
        chk(longint'(ans_c) == x, "ans_c_shift2", longint'(ans_c), x);
        chk(sat_c == s, "sat_c_shift2", longint'(sat_c), longint'(s));
    endtask

    // Scoreboard: push on accept, pop on output handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (in_valid && rdy_a) exp_q.push_back(drv_exp);
            if (ov_a && !out_ready) begin
                stall_seen++;
                chk(!rdy_a && !rdy_b && !rdy_c, "stall_in_ready", longint'(rdy_a), 0);
            end
            if (ov_a && out_ready) begin
                if (exp_q.size() == 0) chk(1'b0, "unexpected_result", longint'(ans_a), 0);
                else begin
                    n_results++;
                    check_result(exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_a && n < 50);
        if (!rdy_a) chk(1'b0, "accept_timeout", n, 50);
    endtask

    task automatic send(input vec_t w, input longint e);
        @(posedge clk); #1;
        window_in = w;
        in_valid  = 1'b1;
        drv_exp   = e;
        wait_accept();
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!ack_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(ack_a && ack_b && ack_c, "kernel_ack_seen", longint'(ack_a), 1);
    endtask

    task automatic load_kernel(input vec_t k);
        @(posedge clk); #1;
        kernel_load = 1'b1;
        kernel_in   = k;
        wait_ack();
        @(posedge clk); #1;
        kernel_load = 1'b0;
        @(negedge clk);
        chk(!ack_a, "ack_one_cycle", longint'(ack_a), 0);
        chk(rdy_a, "ready_after_load", longint'(rdy_a), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || ov_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0, "drain_results", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        vec_rec_t tbl[7];
        vec_t     k1, k2, wpos, wneg, wr;
        int       lat, base;

        k1 = uniform(1, -1, 2);
        k2 = uniform(1, 0, 0);
        tbl[0] = '{test_win(1), 9};
        tbl[1] = '{test_win(-1), -9};
        tbl[2] = '{'0, 0};
        tbl[3] = '{uniform(1, 1, 1), 18};
        tbl[4] = '{uniform(-5, 3, 7), 54};
        tbl[5] = '{uniform(0, 0, longint'(1) <<< 30), 64'sd19327352832};
        tbl[6] = '{uniform(-(longint'(1) <<< 31), 0, 0), -64'sd19327352832};

        // Reset, then windows offered with no kernel loaded.
        in_valid  = 1'b1;
        window_in = tbl[0].win;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk(ans_a == 0 && !sat_a, "reset_ans", longint'(ans_a), 0);
        chk(!ack_a, "reset_ack", longint'(ack_a), 0);
        for (int i = 0; i < 3; i++) begin
            chk(!rdy_a, "unloaded_in_ready", longint'(rdy_a), 0);
            chk(!ov_a, "unloaded_out_valid", longint'(ov_a), 0);
            @(negedge clk);
        end
        idle();
        load_kernel(k1);

        // Single window latency.
        send(tbl[0].win, tbl[0].exp);
        idle();
        lat = 1;
        @(negedge clk);
        while (!ov_a && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk(lat == 3, "latency", lat, 3);
        wait_drain();

        // Table stream back-to-back with a 2-cycle output stall.
        base = n_results;
        fork
            begin
                for (int i = 0; i < 7; i++) send(tbl[i].win, tbl[i].exp);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk(n_results - base == 7, "stream_result_count", n_results - base, 7);
        chk(stall_seen >= 2, "stall_cycles_seen", stall_seen, 2);

        // Reload with two windows in flight; a window offered during the reload waits.
        base = n_results;
        wpos = uniform(20000, 0, 0);
        wneg = uniform(-20000, 0, 0);
        send(tbl[0].win, tbl[0].exp);
        send(tbl[3].win, tbl[3].exp);
        @(posedge clk); #1;
        kernel_load = 1'b1;
        kernel_in   = k2;
        window_in   = wpos;
        drv_exp     = 180000;
        @(negedge clk);
        chk(!rdy_a, "load_priority", longint'(rdy_a), 0);
        @(negedge clk);
        chk(!rdy_a, "drain_in_ready", longint'(rdy_a), 0);
        wait_ack();
        chk(n_results - base == 2, "drained_before_ack", n_results - base, 2);
        @(posedge clk); #1;
        kernel_load = 1'b0;
        wait_accept();
        send(wneg, -180000);
        for (int i = 0; i < 3; i++) begin
            wr = '0;
            for (int e = 0; e < NPROD; e++)
                wr = put(wr, e, longint'($urandom_range(0, 65535)) - 32768);
            send(wr, model_sum(wr, k2));
        end
        idle();
        wait_drain();
        chk(n_results - base == 7, "reload_result_count", n_results - base, 7);

        // Reset in the middle of a stream.
        send(tbl[0].win, model_sum(tbl[0].win, k2));
        send(tbl[3].win, model_sum(tbl[3].win, k2));
        send(tbl[4].win, model_sum(tbl[4].win, k2));
        send(wpos, 180000);
        @(posedge clk); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk(!ov_a && !ov_b && !ov_c, "reset_midstream_out_valid", longint'(ov_a), 0);
        chk(!rdy_a, "reset_midstream_in_ready", longint'(rdy_a), 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset     = 1'b0;
        in_valid  = 1'b1;
        window_in = tbl[0].win;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk(!rdy_a && !ov_a, "post_reset_unloaded", longint'({rdy_a, ov_a}), 0);
        end
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kernel_convolution_stream.md
Name: kernel_convolution_stream

Overview:
Streaming, pipelined successor to the single-shot kernel convolution block. Accepts one KERNEL_SIZE x KERNEL_SIZE x CHANNELS window per cycle over a valid/ready handshake and multiplies it tap-wise against a stored kernel. It accumulates at full precision, applies an arithmetic right shift, and saturates to OUT_W bits. Sits between the line-buffer/window generator and the pixel writer in the filter datapath, with runtime kernel reload that drains in-flight data first.

Parameters:
KERNEL_SIZE, 3, kernel width and height in taps
CHANNELS, 3, channels per tap; channel 0 occupies the MSBs of each tap word
DATA_W, 32, signed width of one channel sample and one kernel coefficient
OUT_W, 32, signed output width after clipping
SHIFT, 0, arithmetic right shift applied to the full sum before clipping

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
kernel_load  in  1  request to latch kernel_in; hold high until kernel_ack
kernel_in  in  KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_W  packed [row][col][channel] coefficients; stable while kernel_load is high
kernel_ack  out  1  one-cycle pulse when the kernel has been latched
in_valid  in  1  window_in is valid
in_ready  out  1  block accepts window_in this cycle
window_in  in  KERNEL_SIZE*KERNEL_SIZE*CHANNELS*DATA_W  packed window, same layout as kernel_in
out_valid  out  1  ans and sat_flag are valid
out_ready  in  1  downstream accepts the result
ans  out  OUT_W  signed clipped convolution result
sat_flag  out  1  ans was clipped

Behaviour:
- Reset: state UNLOADED; all stage valids 0; out_valid, kernel_ack, sat_flag 0; ans 0; kernel registers 0. Reset mid-stream discards in-flight results. A kernel must be reloaded after reset.
- FSM states: UNLOADED, RUN, DRAIN, LOAD.
  - UNLOADED: in_ready=0. kernel_load -> LOAD.
  - LOAD: latch kernel_in, pulse kernel_ack, then -> RUN. Takes one cycle.
  - RUN: kernel_load with pipeline empty -> LOAD. kernel_load with any stage valid -> DRAIN.
  - DRAIN: in_ready=0. When all stage valids including out_valid are 0 -> LOAD.
- in_ready = (state==RUN) && !kernel_load && !stall.
- kernel_load has priority over in_valid in the same cycle: the window is not accepted.
- stall = out_valid && !out_ready. While stalled, every pipeline stage holds its data and valid. There are no bubbles inserted and no drops.
- Pipeline, 3 register stages:
  - S1: per-tap, per-channel signed products, 2*DATA_W bits each.
  - S2: per-row sums.
  - S3: total sum, arithmetic shift right by SHIFT (floor toward -inf), then clip. Registered into ans, sat_flag, out_valid.
- Latency: accept at cycle N -> out_valid at N+3 if not stalled. Throughput is 1 window per cycle.
- Accumulator width ACC_W = 2*DATA_W + clog2(KERNEL_SIZE*KERNEL_SIZE*CHANNELS). No intermediate overflow.
- Clip rules:
  - shifted > 2^(OUT_W-1)-1 -> ans = max, sat_flag=1.
  - shifted < -2^(OUT_W-1) -> ans = min, sat_flag=1.
  - otherwise ans = shifted, sat_flag=0.
- Results emerge in accept order. Each result uses the kernel active when its window was accepted. ans and sat_flag hold their values while out_valid=0.

Test Plan:
1. After reset, hold in_valid=1 with no kernel loaded -> in_ready=0, out_valid stays 0. kernel_load for 1 cycle -> kernel_ack pulses once, then in_ready=1.
2. K=3, C=3, all taps {1,-1,2}, window tap(i,j)={i*j, i+j, j}, accepted at cycle N -> out_valid at N+3, ans=9, sat_flag=0.
3. Stream 4 distinct windows back-to-back with out_ready low for 2 cycles mid-stream -> in_ready low during the stall, 4 results in order, none lost or duplicated.
4. OUT_W=16, kernel channel 0 = 1, others 0, every tap channel 0 = 20000 -> ans=32767, sat_flag=1. Tap value -20000 -> ans=-32768, sat_flag=1.
5. SHIFT=2: sum 9 -> ans=2; sum -9 -> ans=-3.
6. kernel_load raised with 2 windows in flight -> in_ready=0 (DRAIN), both results use the old kernel, then kernel_ack, and the next window uses the new kernel. Asserting reset mid-stream -> out_valid=0 next cycle and state UNLOADED.
